// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive CSR block: CSR addresses,
// muartstat bit positions and the receiver FSM states (UART_RX_PARITY_EN).
package uart_pkg;

    localparam logic [11:0] CSR_MUARTSTAT = 12'hfc0;
    localparam logic [11:0] CSR_MUARTRX   = 12'hfc1;

    localparam int STAT_AVAIL   = 0;
    localparam int STAT_OVR     = 1;
    localparam int STAT_FERR    = 2;
    localparam int STAT_PERR    = 3;
    localparam int STAT_CNT_LSB = 8;
    localparam int RX_VALID     = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO; pointers wrap modulo DEPTH (power of two).
// A push while full is only accepted when a pop frees a slot that cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]    count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    assign full_o  = (count_q == NW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        rd_en    = pop_i && !empty_o;
        wr_en    = push_i && (!full_o || rd_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + NW'(wr_en) - NW'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_rx_csr.sv
// UART receiver feeding a byte FIFO read through muartstat/muartrx CSRs.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking; default 8N1.
module uart_rx_csr
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic        csr_valid,
    input  logic [11:0] csr_addr,
    output logic        csr_hit,
    output logic [31:0] csr_rdata,
    output logic        rx_irq
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int NW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_CNT  = CW'(CLKS_PER_BIT - 1);

    logic          rxd_m_q;
    logic          rxd_s_q;
    rx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          ovr_q;
    logic          ferr_q;
    logic          rx_irq_q;
`ifdef UART_RX_PARITY_EN
    logic          par_q;
    logic          pbad_q;
    logic          perr_q;
`endif

    logic          tick;
    logic          push_req;
    logic          ferr_set;
    logic          perr_set;
    logic          ovr_set;
    logic          stat_sel;
    logic          rx_sel;
    logic          pop;
    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [NW-1:0] fifo_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rxd_m_q <= 1'b1;
            rxd_s_q <= 1'b1;
        end else begin
            rxd_m_q <= rxd;
            rxd_s_q <= rxd_m_q;
        end
    end

    always_comb begin
        tick     = (cnt_q == BIT_CNT);
        ferr_set = (state_q == STOP) && tick && !rxd_s_q;
`ifdef UART_RX_PARITY_EN
        push_req = (state_q == STOP) && tick && rxd_s_q && !pbad_q;
        perr_set = (state_q == PARITY) && tick && (par_q ^ rxd_s_q);
`else
        push_req = (state_q == STOP) && tick && rxd_s_q;
        perr_set = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            pbad_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    bit_q <= '0;
`ifdef UART_RX_PARITY_EN
                    par_q  <= 1'b0;
                    pbad_q <= 1'b0;
`endif
                    if (!rxd_s_q) begin
                        state_q <= START;
                    end
                end
                START: begin
                    // Mid-bit check rejects short low glitches
                    if (cnt_q == HALF_CNT) begin
                        cnt_q   <= '0;
                        state_q <= rxd_s_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (tick) begin
                        cnt_q   <= '0;
                        shift_q <= {rxd_s_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                        par_q <= par_q ^ rxd_s_q;
                        if (bit_q == 3'd7) begin
                            state_q <= PARITY;
                        end
`else
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                        end
`endif
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        cnt_q   <= '0;
                        pbad_q  <= par_q ^ rxd_s_q;
                        state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        cnt_q   <= '0;
                        state_q <= rxd_s_q ? IDLE : BREAK;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                BREAK: begin
                    cnt_q <= '0;
                    if (rxd_s_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        stat_sel = csr_valid && (csr_addr == CSR_MUARTSTAT);
        rx_sel   = csr_valid && (csr_addr == CSR_MUARTRX);
        csr_hit  = stat_sel || rx_sel;
        pop      = rx_sel && !fifo_empty;
        ovr_set  = push_req && fifo_full && !pop;
    end

    // A flag raised in the same cycle as a status read survives the clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
            rx_irq_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q   <= 1'b0;
`endif
        end else begin
            ovr_q    <= ovr_set || (ovr_q && !stat_sel);
            ferr_q   <= ferr_set || (ferr_q && !stat_sel);
            rx_irq_q <= !fifo_empty;
`ifdef UART_RX_PARITY_EN
            perr_q   <= perr_set || (perr_q && !stat_sel);
`endif
        end
    end

    assign rx_irq = rx_irq_q;

    always_comb begin
        csr_rdata = '0;
        if (stat_sel) begin
            csr_rdata[STAT_AVAIL]         = !fifo_empty;
            csr_rdata[STAT_OVR]           = ovr_q;
            csr_rdata[STAT_FERR]          = ferr_q;
`ifdef UART_RX_PARITY_EN
            csr_rdata[STAT_PERR]          = perr_q;
`endif
            csr_rdata[STAT_CNT_LSB +: 8]  = 8'(fifo_cnt);
        end else if (rx_sel && !fifo_empty) begin
            csr_rdata[RX_VALID]           = 1'b1;
            csr_rdata[7:0]                = fifo_head;
        end
    end

    uart_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_req),
        .data_i  (shift_q),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

endmodule

// File: tb/tb_uart_rx_csr.sv
// Scoreboard bench for uart_rx_csr: CSR reads queue expected data,
// a negedge monitor compares whatever the DUT returns.
module tb_uart_rx_csr;
    import uart_pkg::*;

    localparam int C = 16;
    localparam int D = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int PUSH_K = 2 + C / 2 + (9 + PAR) * C + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rxd = 1'b1;
    logic        csr_valid = 1'b0;
    logic [11:0] csr_addr = '0;
    logic        csr_hit;
    logic [31:0] csr_rdata;
    logic        rx_irq;

    typedef struct {
        logic        hit;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    uart_rx_csr #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .csr_valid (csr_valid),
        .csr_addr  (csr_addr),
        .csr_hit   (csr_hit),
        .csr_rdata (csr_rdata),
        .rx_irq    (rx_irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (csr_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_read: hit=%b rdata=%h, no expectation queued",
                         csr_hit, csr_rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (csr_hit !== e.hit || csr_rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL %s: hit=%b rdata=%h, expected hit=%b rdata=%h",
                             e.name, csr_hit, csr_rdata, e.hit, e.data);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bit_drv(input logic b, input int n);
        rxd = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic stop_b = 1'b1,
                        input int stop_n = C, input logic pflip = 1'b0);
        bit_drv(1'b0, C);
        for (int i = 0; i < 8; i++) begin
            bit_drv(d[i], C);
        end
        if (PAR != 0) begin
            bit_drv((^d) ^ pflip, C);
        end
        bit_drv(stop_b, stop_n);
        bit_drv(1'b1, C);
    endtask

    task automatic rd(input string nm, input logic [11:0] a,
                      input logic h, input logic [31:0] d);
        exp_t e;
        e.hit  = h;
        e.data = d;
        e.name = nm;
        exp_q.push_back(e);
        csr_addr  = a;
        csr_valid = 1'b1;
        @(posedge clk);
        #1;
        csr_valid = 1'b0;
        csr_addr  = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        check("irq_reset", 32'(rx_irq), 32'h0);
        rd("stat_reset", CSR_MUARTSTAT, 1'b1, 32'h0);
        rd("rx_empty_reset", CSR_MUARTRX, 1'b1, 32'h0);
        rd("other_addr_miss", 12'h7c0, 1'b0, 32'h0);

        fork
            send(8'hA5);
            begin
                repeat (PUSH_K) @(posedge clk);
                @(negedge clk);
                check("irq_before_push", 32'(rx_irq), 32'h0);
                @(posedge clk);
                @(negedge clk);
                check("irq_after_push", 32'(rx_irq), 32'h1);
            end
        join
        rd("stat_a5", CSR_MUARTSTAT, 1'b1, 32'h0000_0101);
        rd("rx_a5", CSR_MUARTRX, 1'b1, 32'h0000_01A5);
        rd("stat_after_pop", CSR_MUARTSTAT, 1'b1, 32'h0);
        check("irq_after_pop", 32'(rx_irq), 32'h0);

        bit_drv(1'b0, 4);
        bit_drv(1'b1, 3 * C);
        rd("stat_glitch", CSR_MUARTSTAT, 1'b1, 32'h0);

        for (int i = 0; i < 9; i++) begin
            send(8'(i));
        end
        rd("stat_overrun", CSR_MUARTSTAT, 1'b1, 32'h0000_0803);
        for (int i = 0; i < 8; i++) begin
            rd("rx_drain", CSR_MUARTRX, 1'b1, 32'h100 + 32'(i));
        end
        rd("rx_drain_empty", CSR_MUARTRX, 1'b1, 32'h0);
        rd("stat_drained", CSR_MUARTSTAT, 1'b1, 32'h0);

        send(8'h3C, 1'b0, 40);
        rd("stat_ferr", CSR_MUARTSTAT, 1'b1, 32'h0000_0004);
        send(8'h11);
        rd("stat_after_break", CSR_MUARTSTAT, 1'b1, 32'h0000_0101);
        rd("rx_after_break", CSR_MUARTRX, 1'b1, 32'h0000_0111);

        for (int i = 0; i < 8; i++) begin
            send(8'h20 + 8'(i));
        end
        rd("stat_full", CSR_MUARTSTAT, 1'b1, 32'h0000_0801);
        fork
            send(8'h7E);
            begin
                repeat (PUSH_K - 1) @(posedge clk);
                #1;
                rd("rx_pop_with_push", CSR_MUARTRX, 1'b1, 32'h0000_0120);
            end
        join
        rd("stat_pop_push", CSR_MUARTSTAT, 1'b1, 32'h0000_0801);
        for (int i = 1; i < 8; i++) begin
            rd("rx_full_drain", CSR_MUARTRX, 1'b1, 32'h120 + 32'(i));
        end
        rd("rx_last_7e", CSR_MUARTRX, 1'b1, 32'h0000_017E);
        rd("rx_empty_again", CSR_MUARTRX, 1'b1, 32'h0);

`ifdef UART_RX_PARITY_EN
        send(8'h03, 1'b1, C, 1'b1);
        rd("stat_perr", CSR_MUARTSTAT, 1'b1, 32'h0000_0008);
        send(8'h03);
        rd("stat_par_ok", CSR_MUARTSTAT, 1'b1, 32'h0000_0101);
        rd("rx_par_ok", CSR_MUARTRX, 1'b1, 32'h0000_0103);
`endif

        send(8'h55);
        bit_drv(1'b0, 3 * C);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        bit_drv(1'b1, 2 * C);
        check("irq_after_reset", 32'(rx_irq), 32'h0);
        rd("stat_after_reset", CSR_MUARTSTAT, 1'b1, 32'h0);
        rd("rx_after_reset", CSR_MUARTRX, 1'b1, 32'h0);

        repeat (4) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_csr.md
# uart_rx_csr

Serial UART receiver that deserializes 8N1 frames from the board `rxd` pin into a byte FIFO. It exposes them to the core through the read-only machine CSRs `muartstat` (0xfc0) and `muartrx` (0xfc1). It is the receive-side counterpart of the `muarttx` (0x7c0) transmit path and sits beside the CSR file, which forwards reads of these two addresses to it.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; even, ≥4.
- `FIFO_DEPTH`, 8: receive FIFO entries; power of 2, 2–128.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `rxd`  in  1  asynchronous serial input; idles high.
- `csr_valid`  in  1  single-cycle CSR read strobe, non-speculative (issued at retire only).
- `csr_addr`  in  12  CSR address.
- `csr_hit`  out  1  combinational; `csr_valid` & addr ∈ {0xfc0, 0xfc1}.
- `csr_rdata`  out  32  combinational read data; 0 when `csr_hit`=0.
- `rx_irq`  out  1  registered; FIFO non-empty.

## Operation
- `rxd` passes through a 2-flop synchronizer; both flops reset to 1.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
  - IDLE: synced `rxd`=0 → START; bit counter cleared.
  - START: sample at count CLKS_PER_BIT/2−1. If 0 → DATA. If 1 → IDLE as a glitch, with no flag set.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first. After bit 7 → PARITY or STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - If 1: push the byte → IDLE.
    - If 0: set `ferr`, discard the byte → BREAK.
  - BREAK: wait for synced `rxd`=1 → IDLE.
- FIFO push when full: the byte is dropped, `ovr` is set, and the FIFO contents are unchanged.
- `muartstat` read layout:
  - [0] avail (count≠0)
  - [1] `ovr`
  - [2] `ferr`
  - [3] `perr`
  - [15:8] count, zero-extended
  - all other bits 0
  - The read clears `ovr`/`ferr`/`perr` at the clock edge.
- `muartrx` read layout:
  - [7:0] head byte
  - [8] valid
  - If non-empty: pops at the edge.
  - If empty: returns 0 and has no side effect.
- Reset values: all flags 0, FIFO empty, FSM IDLE, `rx_irq`=0, counters 0.

## Timing
- Stop-bit sample, and therefore the FIFO push, occurs at 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the falling start edge reaches `rxd`. With parity the figure is 10·CLKS_PER_BIT.
- `rx_irq` rises 1 cycle after the push edge.
- Pop and push in the same cycle: both take effect and the count is unchanged.
  - If the FIFO was full, the pop frees the slot, the push is accepted, and `ovr` is not set.
- A flag set and a `muartstat` clear in the same cycle: set wins. The read data returns the old value.
- Read pointer and write pointer wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits.
- Reset mid-frame: the frame is abandoned, the FIFO is flushed, and the FSM returns to IDLE on the next edge.
- `csr_rdata` is valid in the same cycle as `csr_valid`. There are no wait states.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The frame is 8E1.
  - PARITY state samples bit 9.
  - Odd total ones sets `perr` and discards the byte.
  - STOP follows PARITY.
- `UART_RX_PARITY_EN` undefined:
  - The frame is 8N1.
  - The PARITY state is absent and `perr` reads constant 0.

## Structure
- `uart_pkg` contains:
  - CSR address constants `CSR_MUARTSTAT`=12'hfc0 and `CSR_MUARTRX`=12'hfc1, shared with the CSR file.
  - `muartstat` bit-position constants.
  - FSM state typedef.
- Sub-module `uart_rx_fifo`: synchronous FIFO with push, pop, full, empty and count, parameterized by width and depth.

## Test plan
All scenarios use CLKS_PER_BIT=16 and FIFO_DEPTH=8.
- Send 0xA5 in 8N1 → push at cycle 2+8+144 after the start edge. `muartstat`=0x00000101. `muartrx`=0x000001A5, then `muartstat`=0x00000000.
- 4-cycle low glitch on `rxd` → no push, no flags, FSM back to IDLE.
- Send 9 bytes 0x00–0x08 without reads → count 8, `ovr`=1. Eight `muartrx` reads return 0x100–0x107. A ninth read returns 0.
- Stop bit driven 0 on byte 0x3C, line held low 40 cycles → `ferr`=1, no push. The next byte 0x11 is received normally once the line returns high.
- FIFO full, and a `muartrx` pop coincides with the stop-sample push of 0x7E → count stays 8 and `ovr`=0. The last entry read is 0x7E.
- With `UART_RX_PARITY_EN`: 0x03 with parity bit 1 → `perr`=1, no push. The same byte with parity bit 0 → push 0x03.
